// File: rtl/mc_alu_pkg.sv
// Shared opcode encodings and FSM state type for the multi-cycle ALU.
package mc_alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_MULH = 4'b0101;
    localparam logic [3:0] OP_DIVU = 4'b0110;
    localparam logic [3:0] OP_REMU = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULH);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/mc_alu_iter.sv
// Shared iterative datapath: shift-add multiply or restoring unsigned divide,
// one bit per step. {hi, lo} is the product, or remainder/quotient.
module mc_alu_iter
    import mc_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             step,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        sum     = {1'b0, hi_q} + {1'b0, b_q};
        shifted = {hi_q, lo_q[WIDTH-1]};
        // diff[WIDTH] set means the trial subtraction borrowed: restore
        diff    = shifted - {1'b0, b_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q <= '0;
            hi_q <= '0;
            b_q  <= '0;
        end else if (load) begin
            lo_q <= a;
            hi_q <= '0;
            b_q  <= b;
        end else if (step) begin
            if (is_div) begin
                if (!diff[WIDTH]) begin
                    hi_q <= diff[WIDTH-1:0];
                    lo_q <= {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_q <= shifted[WIDTH-1:0];
                    lo_q <= {lo_q[WIDTH-2:0], 1'b0};
                end
            end else if (lo_q[0]) begin
                {hi_q, lo_q} <= {sum, lo_q[WIDTH-1:1]};
            end else begin
                {hi_q, lo_q} <= {1'b0, hi_q, lo_q[WIDTH-1:1]};
            end
        end
    end

    assign lo = lo_q;
    assign hi = hi_q;

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU with valid/ready handshake; single-cycle logic ops here,
// multiply/divide delegated to the shared iterative datapath.
//   state | meaning
//   IDLE  | ready for a request; operands captured on in_valid
//   CALC  | iterating multiply/divide, one bit per cycle
//   DONE  | result held with out_valid until out_ready
module mc_alu
    import mc_alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1,
    parameter int DIV_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_cntrl,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             err
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] res_q;
    logic             err_q;
    logic             use_iter_q;
    logic             iter_ok;
    logic             load;
    logic             step;
    logic [WIDTH-1:0] single_res;
    logic             single_err;
    logic             slt;
    logic [WIDTH-1:0] iter_lo;
    logic [WIDTH-1:0] iter_hi;

    assign iter_ok = (is_mul_op(alu_cntrl) && (MUL_EN != 0)) ||
                     (is_div_op(alu_cntrl) && (DIV_EN != 0));
    assign slt     = $signed(data_1) < $signed(data_2);

    always_comb begin
        single_res = '0;
        single_err = 1'b0;
        case (alu_cntrl)
            OP_AND:  single_res = data_1 & data_2;
            OP_OR:   single_res = data_1 | data_2;
            OP_ADD:  single_res = data_1 + data_2;
            OP_SUB:  single_res = data_1 - data_2;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, slt};
            OP_MUL, OP_MULH, OP_DIVU, OP_REMU: single_err = !iter_ok;
            default: single_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = iter_ok;
                    state_d = iter_ok ? CALC : DONE;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt_q == CNT_ONE) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= OP_AND;
            res_q      <= '0;
            err_q      <= 1'b0;
            use_iter_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                op_q       <= alu_cntrl;
                res_q      <= single_res;
                err_q      <= single_err;
                use_iter_q <= iter_ok;
                cnt_q      <= CNT_INIT;
            end else if (state_q == CALC) begin
                cnt_q <= cnt_q - CNT_ONE;
            end
        end
    end

    mc_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .is_div (is_div_op(op_q)),
        .a      (data_1),
        .b      (data_2),
        .step   (step),
        .lo     (iter_lo),
        .hi     (iter_hi)
    );

    // Iterative results are read straight from the datapath registers,
    // which stop stepping once the FSM leaves CALC.
    always_comb begin
        if (!use_iter_q)
            alu_out = res_q;
        else if (op_q == OP_MULH || op_q == OP_REMU)
            alu_out = iter_hi;
        else
            alu_out = iter_lo;
    end

    assign zero = out_valid && (alu_out == '0);
    assign err  = err_q;

endmodule

// File: tb/tb_mc_alu.sv
// Scoreboard bench for mc_alu: randomized and directed requests checked
// against an arithmetic reference model, plus a DIV_EN=0 instance.
module tb_mc_alu;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int           lat;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   alu_cntrl = 4'd0;
    logic [W-1:0] data_1 = '0;
    logic [W-1:0] data_2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] alu_out;
    logic         zero;
    logic         err;

    logic         in_valid2 = 1'b0;
    logic         in_ready2;
    logic         out_valid2;
    logic         out_ready2 = 1'b0;
    logic [W-1:0] alu_out2;
    logic         zero2;
    logic         err2;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t exp_q[$];

    mc_alu #(.WIDTH(W), .MUL_EN(1), .DIV_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_cntrl(alu_cntrl), .data_1(data_1), .data_2(data_2),
        .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
        .zero(zero), .err(err)
    );

    mc_alu #(.WIDTH(W), .MUL_EN(1), .DIV_EN(0)) dut_nodiv (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .alu_cntrl(alu_cntrl), .data_1(data_1), .data_2(data_2),
        .out_valid(out_valid2), .out_ready(out_ready2), .alu_out(alu_out2),
        .zero(zero2), .err(err2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, expv);
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [2*W-1:0] p;
        p     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.res = '0;
        e.err = 1'b0;
        e.lat = 1;
        e.acc = 0;
        case (op)
            4'd0: e.res = a & b;
            4'd1: e.res = a | b;
            4'd2: e.res = a + b;
            4'd3: e.res = a - b;
            4'd4: e.res = p[W-1:0];
            4'd5: e.res = p[2*W-1:W];
            4'd6: e.res = (b == 0) ? '1 : a / b;
            4'd7: e.res = (b == 0) ? a : a % b;
            4'd8: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
            default: e.err = 1'b1;
        endcase
        if (op >= 4'd4 && op <= 4'd7) e.lat = W + 1;
        return e;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        int           n;
        logic         busy_ok;
        logic         stable_ok;
        logic [W-1:0] held;
        exp_t         e;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        check("in_ready wait", in_ready, 1);
        out_ready = (hold == 0);
        alu_cntrl = op; data_1 = a; data_2 = b; in_valid = 1'b1;
        e = model(op, a, b);
        e.acc = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        alu_cntrl = 4'($urandom); data_1 = $urandom; data_2 = $urandom;
        busy_ok = 1'b1;
        n = 0;
        while (!out_valid && n < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check("out_valid timeout", out_valid, 1);
        check("in_ready low while busy", busy_ok & ~in_ready, 1);
        if (hold > 0) begin
            held = alu_out;
            stable_ok = 1'b1;
            repeat (hold) begin
                in_valid = 1'b1;
                @(negedge clk);
                if (!out_valid || in_ready || alu_out !== held) stable_ok = 1'b0;
            end
            check("backpressure hold", stable_ok, 1);
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b0;
        check("idle after handshake", {in_ready, out_valid}, 2'b10);
    endtask

    // Monitor: one scoreboard entry per out_valid rising edge
    initial begin
        logic ov_prev;
        exp_t e;
        ov_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid && !ov_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected out_valid", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("alu_out", alu_out, e.res);
                    check("zero", zero, e.res == '0);
                    check("err", err, e.err);
                    check("latency", cyc - e.acc, e.lat);
                end
            end
            ov_prev = out_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           sel;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset alu_out", alu_out, 0);
        check("reset zero", zero, 0);
        check("reset err", err, 0);

        // Abort a multiply mid-iteration with a one-cycle reset pulse
        alu_cntrl = 4'd4; data_1 = 32'h1234_5678; data_2 = 32'h9abc_def0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid-calc busy", in_ready, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort in_ready", in_ready, 1);
        check("abort out_valid", out_valid, 0);
        check("abort alu_out", alu_out, 0);
        @(negedge clk);
        check("abort no output", out_valid, 0);
        out_ready = 1'b0;
        issue(4'd2, 32'd5, 32'd7, 0);

        issue(4'd2, 32'hFFFF_FFFF, 32'd1, 0);
        issue(4'd3, 32'd3, 32'd5, 0);
        issue(4'd8, 32'hFFFF_FFFF, 32'd1, 0);
        issue(4'd8, 32'd1, 32'hFFFF_FFFF, 0);
        issue(4'd4, 32'h0001_0000, 32'h0001_0000, 0);
        issue(4'd5, 32'h0001_0000, 32'h0001_0000, 0);
        issue(4'd6, 32'd100, 32'd7, 0);
        issue(4'd7, 32'd100, 32'd7, 0);
        issue(4'd6, 32'h1234, 32'd0, 0);
        issue(4'd7, 32'h1234, 32'd0, 0);
        issue(4'd15, 32'hDEAD_BEEF, 32'h1, 0);
        issue(4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 10);
        issue(4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10);
        issue(4'd1, 32'h0000_00F0, 32'h0000_000F, 0);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 11);
            op  = (sel > 8) ? 4'($urandom_range(9, 15)) : 4'(sel);
            a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
            b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            issue(op, a, b, $urandom_range(0, 3));
        end

        // DIV_EN=0 instance: DIVU is an illegal opcode with latency 1
        @(negedge clk);
        check("nodiv idle", in_ready2, 1);
        alu_cntrl = 4'd6; data_1 = 32'd100; data_2 = 32'd7;
        in_valid2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
        check("nodiv out_valid latency", out_valid2, 1);
        check("nodiv err", err2, 1);
        check("nodiv alu_out", alu_out2, 0);
        check("nodiv zero", zero2, 1);
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
        check("nodiv idle after", {in_ready2, out_valid2}, 2'b10);

        repeat (2) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
